rom_loader: RTL and testbench

//  Boot sequencer for the Hack CPU. Holds the CPU in reset and receives a program image

---
 rtl/rom_loader.sv | 197 +++++++++++++++++++
 tb/tb_rom_loader.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/rom_loader.sv
// Boot sequencer: receives a framed program image over the UART byte stream,
// writes it into instruction ROM, verifies the checksum and releases the CPU.
module rom_loader #(
    parameter int ADDR_WIDTH     = 12,
    parameter int TIMEOUT_CYCLES = 12_000_000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    output logic                  rom_we,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    output logic [15:0]           rom_wdata,
    output logic                  cpu_reset,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [16:0]   MAX_LEN  = 17'(2 ** ADDR_WIDTH);
    localparam logic [7:0]    SYNC     = 8'hA5;

    typedef enum logic [2:0] {
        S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA_HI,
        S_DATA_LO, S_CHECK, S_RUN, S_ERR
    } state_t;

    state_t                  state_q, state_d;
    logic [15:0]             len_q, len_d;
    logic [7:0]              hi_q, hi_d;
    logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
    logic [7:0]              chk_q, chk_d;
    logic [TW-1:0]           tmo_q, tmo_d;
    logic                    we_q, we_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [15:0]             wdata_q, wdata_d;
    logic                    cpu_rst_q, cpu_rst_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;

    logic                    in_frame;
    logic                    go_err;
    logic [15:0]             len_full;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            len_q     <= '0;
            hi_q      <= '0;
            idx_q     <= '0;
            chk_q     <= '0;
            tmo_q     <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            cpu_rst_q <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            hi_q      <= hi_d;
            idx_q     <= idx_d;
            chk_q     <= chk_d;
            tmo_q     <= tmo_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            cpu_rst_q <= cpu_rst_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign in_frame = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                      (state_q == S_DATA_HI) || (state_q == S_DATA_LO) ||
                      (state_q == S_CHECK);
    assign len_full = {len_q[15:8], rx_data};

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        hi_d      = hi_q;
        idx_d     = idx_q;
        chk_d     = chk_q;
        tmo_d     = tmo_q;
        we_d      = 1'b0;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        cpu_rst_d = cpu_rst_q;
        busy_d    = busy_q;
        done_d    = done_q;
        err_d     = err_q;
        go_err    = 1'b0;

        unique case (state_q)
            S_IDLE, S_RUN, S_ERR: begin
                if (rx_valid && rx_data == SYNC) begin
                    state_d   = S_LEN_HI;
                    busy_d    = 1'b1;
                    cpu_rst_d = 1'b1;
                    done_d    = 1'b0;
                    err_d     = 1'b0;
                    chk_d     = '0;
                    idx_d     = '0;
                    tmo_d     = '0;
                end
            end
            S_LEN_HI: begin
                if (rx_valid) begin
                    len_d[15:8] = rx_data;
                    state_d     = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (rx_valid) begin
                    len_d = len_full;
                    if ({1'b0, len_full} > MAX_LEN) begin
                        go_err = 1'b1;
                    end else if (len_full == 16'd0) begin
                        state_d = S_CHECK;
                    end else begin
                        state_d = S_DATA_HI;
                    end
                end
            end
            S_DATA_HI: begin
                if (rx_valid) begin
                    hi_d    = rx_data;
                    chk_d   = chk_q + rx_data;
                    state_d = S_DATA_LO;
                end
            end
            S_DATA_LO: begin
                if (rx_valid) begin
                    chk_d   = chk_q + rx_data;
                    we_d    = 1'b1;
                    wdata_d = {hi_q, rx_data};
                    addr_d  = idx_q;
                    idx_d   = idx_q + ADDR_WIDTH'(1);
                    // LEN is bounded to the ROM size, so LEN-1 fits the index width
                    if (idx_q == ADDR_WIDTH'(len_q - 16'd1)) begin
                        state_d = S_CHECK;
                    end else begin
                        state_d = S_DATA_HI;
                    end
                end
            end
            S_CHECK: begin
                if (rx_valid) begin
                    if (rx_data == chk_q) begin
                        state_d   = S_RUN;
                        busy_d    = 1'b0;
                        done_d    = 1'b1;
                        cpu_rst_d = 1'b0;
                    end else begin
                        go_err = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (in_frame) begin
            if (rx_valid) begin
                tmo_d = '0;
            end else if (tmo_q == TMO_LAST) begin
                go_err = 1'b1;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end

        if (go_err) begin
            state_d   = S_ERR;
            busy_d    = 1'b0;
            err_d     = 1'b1;
            cpu_rst_d = 1'b1;
            done_d    = 1'b0;
            tmo_d     = '0;
        end
    end

    assign rom_we    = we_q;
    assign rom_addr  = addr_q;
    assign rom_wdata = wdata_q;
    assign cpu_reset = cpu_rst_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = err_q;

endmodule

// File: tb/tb_rom_loader.sv
// Randomized bench for rom_loader: frames are built from word lists, expected
// ROM writes go to a scoreboard queue checked by an independent monitor.
module tb_rom_loader;

    localparam int AW   = 4;
    localparam int TMO  = 16;
    localparam int MAXW = 1 << AW;

    logic          clk = 1'b0;
    logic          reset;
    logic          rx_valid;
    logic [7:0]    rx_data;
    logic          rom_we;
    logic [AW-1:0] rom_addr;
    logic [15:0]   rom_wdata;
    logic          cpu_reset;
    logic          busy;
    logic          done;
    logic          error;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [AW-1:0] a;
        logic [15:0]   d;
    } wr_t;

    wr_t         exp_q[$];
    logic [15:0] wq[$];

    rom_loader #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
        .rom_we(rom_we), .rom_addr(rom_addr), .rom_wdata(rom_wdata),
        .cpu_reset(cpu_reset), .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        wr_t e;
        if (!reset && rom_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected none",
                         rom_addr, rom_wdata);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", 32'(rom_addr), 32'(e.a));
                check("wr_data", 32'(rom_wdata), 32'(e.d));
            end
        end
    end

    task automatic status(input string tag, input bit b, input bit c,
                          input bit d, input bit e);
        check({tag, "_busy"}, 32'(busy), 32'(b));
        check({tag, "_cpu_reset"}, 32'(cpu_reset), 32'(c));
        check({tag, "_done"}, 32'(done), 32'(d));
        check({tag, "_error"}, 32'(error), 32'(e));
    endtask

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic gap(input int gmax);
        int n;
        n = $urandom_range(0, gmax);
        if (n > 0) idle(n);
    endtask

    // Sends a whole frame of LEN words taken from wq and checks the outcome.
    task automatic frame(input int len, input bit corrupt, input int gmax);
        int   sum;
        logic [7:0] chk;
        wr_t  e;
        send(8'hA5);
        status("sync", 1, 1, 0, 0);
        gap(gmax);
        send(8'(len >> 8));
        gap(gmax);
        send(8'(len));
        if (len > MAXW) begin
            status("oversize", 0, 1, 0, 1);
            return;
        end
        sum = 0;
        for (int i = 0; i < len; i++) begin
            e.a = AW'(i);
            e.d = wq[i];
            exp_q.push_back(e);
            sum += int'(wq[i][15:8]) + int'(wq[i][7:0]);
            gap(gmax);
            send(wq[i][15:8]);
            gap(gmax);
            send(wq[i][7:0]);
        end
        chk = 8'(sum % 256);
        if (corrupt) chk = chk ^ 8'(1 << $urandom_range(0, 7));
        gap(gmax);
        send(chk);
        check("wr_drain", 32'(exp_q.size()), 32'd0);
        if (corrupt) status("badchk", 0, 1, 0, 1);
        else status("good", 0, 0, 1, 0);
    endtask

    task automatic junk(input int n);
        logic [7:0] b;
        for (int i = 0; i < n; i++) begin
            b = 8'($urandom_range(0, 255));
            if (b == 8'hA5) b = 8'h00;
            send(b);
        end
    endtask

    initial begin
        int len;
        bit st_d, st_e;
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        idle(2);
        status("reset", 0, 1, 0, 0);
        check("reset_we", 32'(rom_we), 32'd0);
        check("reset_addr", 32'(rom_addr), 32'd0);
        check("reset_wdata", 32'(rom_wdata), 32'd0);
        reset = 1'b0;
        idle(1);

        junk(3);
        status("idle_junk", 0, 1, 0, 0);

        wq = '{16'h1234, 16'hABCD};
        frame(2, 0, 0);
        wq = '{16'h1234, 16'hABCD};
        frame(2, 1, 1);
        wq = '{};
        frame(0, 0, 0);

        send(8'hA5);
        send(8'h00);
        send(8'h01);
        send(8'h12);
        idle(TMO - 4);
        status("tmo_early", 1, 1, 0, 0);
        idle(5);
        status("tmo", 0, 1, 0, 1);
        check("tmo_nowrite", 32'(exp_q.size()), 32'd0);

        wq = '{16'hCAFE};
        frame(1, 0, 2);
        wq = '{16'hA5A5, 16'h00A5, 16'hA500};
        frame(3, 0, 0);
        junk(2);
        status("run_junk", 0, 0, 1, 0);

        frame(17, 0, 0);
        for (int i = 0; i < MAXW; i++) wq[i] = 16'($urandom);
        frame(MAXW, 0, 1);

        for (int f = 0; f < 60; f++) begin
            if ($urandom_range(0, 2) == 0) junk($urandom_range(1, 3));
            len = $urandom_range(0, MAXW + 2);
            wq = '{};
            for (int i = 0; i < len && i < MAXW; i++) wq.push_back(16'($urandom));
            frame(len, $urandom_range(0, 3) == 0, 2);
        end

        st_d = done;
        st_e = error;
        send(8'hA5);
        send(8'h00);
        send(8'h01);
        reset = 1'b1;
        idle(1);
        status("midreset", 0, 1, 0, 0);
        check("midreset_we", 32'(rom_we), 32'd0);
        check("midreset_addr", 32'(rom_addr), 32'd0);
        check("midreset_wdata", 32'(rom_wdata), 32'd0);
        reset = 1'b0;
        idle(1);
        send(8'h12);
        send(8'h34);
        idle(2);
        check("post_reset_ignored", 32'(exp_q.size()), 32'd0);
        status("post_reset_idle", 0, 1, 0, 0);
        wq = '{16'h0F0F, 16'hF0F0};
        frame(2, 0, 1);

        idle(3);
        check("final_drain", 32'(exp_q.size()), 32'd0);
        if (st_d && st_e) check("status_exclusive", 32'd1, 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
